// File: rtl/mdu_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mdu_ctrl : HI/LO multiply-divide unit sequencer (E stage, 5-stage MIPS)
//
// Accepts one mult/div-class op at a time, models its fixed latency with a
// BUSY state, writes HI/LO on completion and stalls D-stage HI/LO-class ops
// while the unit is occupied.
//
// Optional feature macro: MDU_MADD_EN
//   defined   : op 100..111 (madd/maddu/msub/msubu) accumulate into {hi,lo}
//   undefined : a start with op[2]=1 is ignored; no accumulate datapath
//
// Parameters
//   MULT_LAT  busy cycles for mult-class ops (1..15)
//   DIV_LAT   busy cycles for div/divu      (1..15)
//
// Ports
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     E-stage op is mult/div-class
//   op        000 mult 001 multu 010 div 011 divu 1xx madd/maddu/msub/msubu
//   a, b      rs / rt operands
//   mthi/mtlo E-stage move-to-HI/LO, data on wdata
//   md_use_D  D-stage instruction is HI/LO-class
//   busy      operation in flight
//   stall_D   freeze F/D, bubble into E
//   done      one-cycle pulse after HI/LO are written
//   hi, lo    architectural HI/LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_D,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        w_accept, w_finish, w_op_ok, w_is_div;

   logic [1:0]  r_op;
   logic [31:0] r_a, r_b, r_hi, r_lo;
   logic        r_done;

`ifdef MDU_MADD_EN
   logic        r_acc, r_sub;
   logic [63:0] r_hl;
   assign w_op_ok = 1'b1;
`else
   // Accumulate ops are not supported in this build; treat as no-op.
   assign w_op_ok = ~op[2];
`endif

   assign w_is_div = (op[2:1] == 2'b01);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && w_op_ok) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = w_is_div ? 4'(DIV_LAT - 1) : 4'(MULT_LAT - 1);
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath (from latched operands) ----------------
   logic        w_sgn;
   logic [63:0] w_ea, w_eb, w_prod;
   logic        w_neg_a, w_neg_b;
   logic [31:0] w_mag_a, w_mag_b, w_uq, w_ur, w_q, w_r;
   logic [63:0] w_div_res, w_res;

   // op[0]=0 selects the signed variant for every op class.
   assign w_sgn  = ~r_op[0];
   // Sign-extending to 64 bits and keeping the low 64 product bits gives the
   // correct signed product with a single unsigned multiplier.
   assign w_ea   = {{32{w_sgn & r_a[31]}}, r_a};
   assign w_eb   = {{32{w_sgn & r_b[31]}}, r_b};
   assign w_prod = w_ea * w_eb;

   // Signed divide via magnitudes: quotient sign = sign(a)^sign(b),
   // remainder sign = sign(a). 0x80000000/-1 wraps naturally to 0x80000000 r 0.
   assign w_neg_a = w_sgn & r_a[31];
   assign w_neg_b = w_sgn & r_b[31];
   assign w_mag_a = w_neg_a ? -r_a : r_a;
   assign w_mag_b = w_neg_b ? -r_b : r_b;
   assign w_uq    = (w_mag_b == 32'd0) ? 32'd0 : w_mag_a / w_mag_b;
   assign w_ur    = (w_mag_b == 32'd0) ? 32'd0 : w_mag_a % w_mag_b;
   assign w_q     = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
   assign w_r     = w_neg_a ? -w_ur : w_ur;
   assign w_div_res = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF} : {w_r, w_q};

`ifdef MDU_MADD_EN
   always_comb begin
      w_res = r_op[1] ? w_div_res : w_prod;
      if (r_acc) w_res = r_sub ? (r_hl - w_prod) : (r_hl + w_prod);
   end
`else
   assign w_res = r_op[1] ? w_div_res : w_prod;
`endif

   // ---------------- HI/LO and operand latches ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op   <= 2'd0;
         r_a    <= 32'd0;
         r_b    <= 32'd0;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_done <= 1'b0;
`ifdef MDU_MADD_EN
         r_acc  <= 1'b0;
         r_sub  <= 1'b0;
         r_hl   <= 64'd0;
`endif
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_op <= op[1:0];
            r_a  <= a;
            r_b  <= b;
`ifdef MDU_MADD_EN
            r_acc <= op[2];
            r_sub <= op[2] & op[1];
            r_hl  <= {r_hi, r_lo};
`endif
         end else if (w_finish) begin
            {r_hi, r_lo} <= w_res;
         end else if (r_state == S_IDLE && !start) begin
            // A raw start (even an unsupported one) still drops mthi/mtlo.
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
         end
      end
   end

   assign busy    = (r_state == S_BUSY);
   // start term covers an op in E with a HI/LO consumer already in D.
   assign stall_D = md_use_D & (busy | start);
   assign done    = r_done;
   assign hi      = r_hi;
   assign lo      = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
`timescale 1ns/1ps
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset_n, start, mthi, mtlo, md_use_D;
   logic [2:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, stall_D, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic [63:0] sb[$];

   mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .md_use_D(md_use_D),
      .busy(busy), .stall_D(stall_D), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic int lat(input logic [2:0] o);
      return (o == 3'd2 || o == 3'd3) ? 10 : 5;
   endfunction

   // Reference model: language-level arithmetic on 64-bit / int types.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, h, l);
      int sx, sy;
      longint sp;
      logic [63:0] up, p;
      sx = x; sy = y;
      sp = longint'(sx) * longint'(sy);
      up = {32'd0, x} * {32'd0, y};
      p  = o[0] ? up : 64'(sp);
      case (o)
         3'd2: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sx % sy), 32'(sx / sy)};
         end
         3'd3: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         3'd4, 3'd5: return {h, l} + p;
         3'd6, 3'd7: return {h, l} - p;
         default: return p;
      endcase
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, y,
                         input logic use_d, input logic with_mt);
      int n;
      logic [63:0] exp;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1; md_use_D = use_d;
      if (with_mt) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
      sb.push_back(model(o, x, y, m_hi, m_lo));
      #1;
      checks++;
      if (stall_D !== use_d) begin errors++; $display("FAIL stall_start got %b exp %b", stall_D, use_d); end
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (with_mt) begin
         checks++;
         if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL mt_dropped got %h exp %h", {hi, lo}, {m_hi, m_lo});
         end
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         checks++;
         if (stall_D !== use_d) begin errors++; $display("FAIL stall_busy cyc %0d got %b exp %b", n, stall_D, use_d); end
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != lat(o)) begin errors++; $display("FAIL busy_len op %0d got %0d exp %0d", o, n, lat(o)); end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL done_hi got %b exp 1", done); end
      checks++;
      if (stall_D !== 1'b0) begin errors++; $display("FAIL stall_done got %b exp 0", stall_D); end
      exp = sb.pop_front();
      checks++;
      if ({hi, lo} !== exp) begin
         errors++; $display("FAIL result op %0d a %h b %h got %h exp %h", o, x, y, {hi, lo}, exp);
      end
      {m_hi, m_lo} = exp;
      md_use_D = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", done); end
   endtask

   task automatic set_hilo(input logic [31:0] h, l);
      @(negedge clk); mthi = 1'b1; wdata = h;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = l;
      @(negedge clk); mtlo = 1'b0;
      m_hi = h; m_lo = l;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; md_use_D = 1'b0;
      op = 3'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, stall_D, hi, lo} !== 67'd0) begin
         errors++; $display("FAIL reset_state got %h exp 0", {busy, done, stall_D, hi, lo});
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult;
      run_op(3'd0, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b0);
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF4) begin
         errors++; $display("FAIL mult_neg3x4 got %h exp FFFFFFFFFFFFFFF4", {hi, lo});
      end
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
   endtask

   task automatic test_div;
      run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
      checks++;
      if ({hi, lo} !== {32'd1, 32'd3}) begin errors++; $display("FAIL divu_7_2 got %h exp 0000000100000003", {hi, lo}); end
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h exp FFFFFFFFFFFFFFFD", {hi, lo}); end
      run_op(3'd2, 32'd5, 32'd0, 1'b0, 1'b0);
      checks++;
      if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_by0 got %h exp 00000005FFFFFFFF", {hi, lo}); end
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      checks++;
      if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL div_ovf got %h exp 0000000080000000", {hi, lo}); end
      run_op(3'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
      run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] o;
         logic [31:0] x, y;
         o = 3'($urandom_range(0, 3));
         x = $urandom;
         y = (i % 2 == 1) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
         run_op(o, x, y, 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   task automatic test_stall;
      run_op(3'd0, 32'd3, 32'd9, 1'b1, 1'b0);
   endtask

   task automatic test_mt;
      set_hilo(32'h1234_5678, 32'h9ABC_DEF0);
      checks++;
      if ({hi, lo} !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL mthi_mtlo got %h exp 123456789ABCDEF0", {hi, lo}); end
      @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55AA_33CC;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
      checks++;
      if ({hi, lo} !== {2{32'h55AA_33CC}}) begin errors++; $display("FAIL mt_both got %h exp 55AA33CC55AA33CC", {hi, lo}); end
      m_hi = 32'h55AA_33CC; m_lo = 32'h55AA_33CC;
      run_op(3'd0, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b1);
   endtask

   task automatic test_madd;
`ifdef MDU_MADD_EN
      set_hilo(32'd0, 32'hFFFF_FFFF);
      run_op(3'd5, 32'd1, 32'd1, 1'b0, 1'b0);
      checks++;
      if ({hi, lo} !== {32'd1, 32'd0}) begin errors++; $display("FAIL maddu got %h exp 0000000100000000", {hi, lo}); end
      set_hilo(32'd0, 32'd0);
      run_op(3'd6, 32'd1, 32'd1, 1'b0, 1'b0);
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL msub got %h exp FFFFFFFFFFFFFFFF", {hi, lo}); end
      run_op(3'd4, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      run_op(3'd7, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
`else
      set_hilo(32'd0, 32'hFFFF_FFFF);
      @(negedge clk); start = 1'b1; op = 3'd5; a = 32'd1; b = 32'd1; md_use_D = 1'b1;
      #1;
      checks++;
      if (stall_D !== 1'b1) begin errors++; $display("FAIL madd_off_stall got %b exp 1", stall_D); end
      @(negedge clk); start = 1'b0; md_use_D = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL madd_off_busy got %b exp 0", busy); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({done, busy, hi, lo} !== {2'b00, m_hi, m_lo}) begin
            errors++; $display("FAIL madd_off_hold got %h exp %h", {done, busy, hi, lo}, {2'b00, m_hi, m_lo});
         end
      end
`endif
   endtask

   task automatic test_reset_abort;
      set_hilo(32'hCAFE_0001, 32'hCAFE_0002);
      @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b exp 1", busy); end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin errors++; $display("FAIL abort_imm got %h exp 0", {busy, done, hi, lo}); end
      @(negedge clk); reset_n = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         checks++;
         if ({busy, done, hi, lo} !== 66'd0) begin
            errors++; $display("FAIL abort_late cyc %0d got %h exp 0", i, {busy, done, hi, lo});
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_stall();
      test_mt();
      test_madd();
      test_random();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
